// File: rtl/tx_arb_pkg.sv
// Shared types and widths for the TX message arbiter.
// Optional statistics outputs are enabled by defining ARB_STATS_EN.
package tx_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int MSG_TYPE_W = 8;
    localparam int MSG_DATA_W = 32;
    localparam int STAT_MSG_W = 16;

endpackage

// File: rtl/tx_msg_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int SRC_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    int idx;

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        idx     = 0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                gnt_idx = SRC_W'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_msg_arbiter.sv
// Shares the Logic->TX stage between message sources with per-message
// round-robin and grant locking. Define ARB_STATS_EN for msg/stall counters.
module tx_msg_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TYPE_W  = MSG_TYPE_W,
    parameter int DATA_W  = MSG_DATA_W,
    localparam int SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*TYPE_W-1:0]   req_type,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [TYPE_W-1:0]           out_type,
    output logic [DATA_W-1:0]           out_data,
    output logic [SRC_W-1:0]            out_src,
    output logic                        out_last,
    input  logic                        out_ready,
    input  logic [31:0]                 cycle_cnt,
    output logic [31:0]                 t_grant,
`ifdef ARB_STATS_EN
    output logic [NUM_REQ*STAT_MSG_W-1:0] msg_cnt,
    output logic [31:0]                 stall_cnt,
`endif
    output logic                        busy
);

    arb_state_t        state_q, state_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]  lock_idx_q, lock_idx_d;
    logic [31:0]       t_grant_q, t_grant_d;

    logic              out_valid_q;
    logic [TYPE_W-1:0] out_type_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SRC_W-1:0]  out_src_q;
    logic              out_last_q;

    logic [SRC_W-1:0]  rr_idx;
    logic              rr_vld;
    logic [SRC_W-1:0]  grant_idx;
    logic              grant_vld;
    logic [SRC_W-1:0]  nxt_ptr;
    logic              can_accept;
    logic              xfer;
    logic              sel_last;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    // Grant source: round-robin while idle, pinned to the owner while locked.
    always_comb begin
        grant_idx = rr_idx;
        grant_vld = rr_vld;
        if (state_q == ARB_LOCKED) begin
            grant_idx = lock_idx_q;
            grant_vld = req_valid[lock_idx_q];
        end
    end

    assign can_accept = !out_valid_q || out_ready;
    assign xfer       = can_accept && grant_vld;
    assign sel_last   = req_last[grant_idx];
    assign nxt_ptr    = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0
                                                           : grant_idx + 1'b1;

    // Ready only to the granted requester, and only if the register can load.
    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[grant_idx] = 1'b1;
    end

    // Arbitration state: lock on a non-last first beat, rotate on last beat.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        t_grant_d  = t_grant_q;
        if (xfer) begin
            unique case (state_q)
                ARB_IDLE: begin
                    t_grant_d = cycle_cnt;
                    if (sel_last) begin
                        rr_ptr_d = nxt_ptr;
                    end else begin
                        lock_idx_d = grant_idx;
                        state_d    = ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (sel_last) begin
                        rr_ptr_d = nxt_ptr;
                        state_d  = ARB_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            t_grant_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            t_grant_q  <= t_grant_d;
        end
    end

    // Output register: load on transfer, drop valid once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_type_q  <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_type_q  <= req_type[grant_idx*TYPE_W +: TYPE_W];
            out_data_q  <= req_data[grant_idx*DATA_W +: DATA_W];
            out_src_q   <= grant_idx;
            out_last_q  <= sel_last;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_type  = out_type_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;
    assign t_grant   = t_grant_q;
    assign busy      = (state_q == ARB_LOCKED);

`ifdef ARB_STATS_EN
    logic [STAT_MSG_W-1:0] msg_cnt_q [NUM_REQ];
    logic [31:0]           stall_cnt_q;

    // Saturating per-source completed-message and output-stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) msg_cnt_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer && sel_last && grant_idx == SRC_W'(i) &&
                    msg_cnt_q[i] != '1)
                    msg_cnt_q[i] <= msg_cnt_q[i] + 1'b1;
            end
            if (out_valid_q && !out_ready && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Pack the per-source counters onto the flat output bus.
    always_comb begin
        msg_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++)
            msg_cnt[i*STAT_MSG_W +: STAT_MSG_W] = msg_cnt_q[i];
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tx_msg_arbiter.sv
// Randomized scoreboard bench for tx_msg_arbiter against a message-level
// reference model (round-robin per message, lock until last beat).
module tb_tx_msg_arbiter;

    localparam int N  = 4;
    localparam int TW = 8;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*TW-1:0] req_type;
    logic [N*DW-1:0] req_data;
    logic            out_valid, out_last, out_ready, busy;
    logic [TW-1:0]   out_type;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic [31:0]     cyc = '0;
    logic [31:0]     t_grant;
`ifdef ARB_STATS_EN
    logic [N*16-1:0] msg_cnt;
    logic [31:0]     stall_cnt;
`endif

    tx_msg_arbiter #(.NUM_REQ(N), .TYPE_W(TW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_type  (req_type),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_type  (out_type),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready),
        .cycle_cnt (cyc),
        .t_grant   (t_grant),
`ifdef ARB_STATS_EN
        .msg_cnt   (msg_cnt),
        .stall_cnt (stall_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TW-1:0] typ;
        logic [DW-1:0] data;
        int            src;
        logic          last;
        logic [31:0]   tg;
    } beat_t;

    beat_t exp_q[$];
    beat_t pend;
    bit    have_pend;

    int checks   = 0;
    int failures = 0;

    // Reference model: message-level arbitration state.
    int          rr;
    int          lock;
    bit          exp_ov;
    logic [31:0] cur_tg;
    int          beats_left[N];
    int          pv, pr, maxlen;
    int          stall_exp;
    int          msg_exp[N];

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        rr        = 0;
        lock      = -1;
        exp_ov    = 1'b0;
        cur_tg    = '0;
        stall_exp = 0;
        for (int i = 0; i < N; i++) begin
            beats_left[i] = 0;
            msg_exp[i]    = 0;
        end
        exp_q.delete();
        have_pend = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (beats_left[i] == 0) beats_left[i] = $urandom_range(1, maxlen);
            req_valid[i] = ($urandom_range(0, 99) < pv);
            req_last[i]  = (beats_left[i] == 1);
            req_type[i*TW +: TW] = 8'((i << 4) | (beats_left[i] & 15));
            req_data[i*DW +: DW] = $urandom;
        end
        out_ready = ($urandom_range(0, 99) < pr);
    endtask

    // Evaluate the expected grant for this cycle and predict the transfer.
    task automatic model_step();
        int          g;
        bit          gv;
        bit          can;
        logic [N-1:0] er;
        g  = 0;
        gv = 1'b0;
        if (lock >= 0) begin
            g  = lock;
            gv = req_valid[lock];
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!gv && req_valid[(rr + k) % N]) begin
                    g  = (rr + k) % N;
                    gv = 1'b1;
                end
            end
        end
        can = !exp_ov || out_ready;
        er  = '0;
        if (can && gv) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("busy", 64'(busy), 64'(lock >= 0));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov && !out_ready) stall_exp++;
        if (can && gv) begin
            if (lock < 0) cur_tg = cyc;
            pend.typ  = req_type[g*TW +: TW];
            pend.data = req_data[g*DW +: DW];
            pend.src  = g;
            pend.last = req_last[g];
            pend.tg   = cur_tg;
            have_pend = 1'b1;
            beats_left[g]--;
            if (req_last[g]) begin
                rr   = (g + 1) % N;
                lock = -1;
                msg_exp[g]++;
            end else begin
                lock = g;
            end
            exp_ov = 1'b1;
        end else if (out_ready) begin
            exp_ov = 1'b0;
        end
    endtask

    task automatic run_cycles(int n);
        repeat (n) begin
            @(posedge clk);
            if (have_pend) begin
                exp_q.push_back(pend);
                have_pend = 1'b0;
            end
            #1;
            drive();
            @(negedge clk);
            model_step();
        end
    endtask

    // Monitor: every beat drained downstream must match the scoreboard head.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=src%0d required=none",
                         out_src);
            end else begin
                e = exp_q.pop_front();
                chk("out_src", 64'(out_src), 64'(e.src));
                chk("out_type", 64'(out_type), 64'(e.typ));
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_last", 64'(out_last), 64'(e.last));
                chk("t_grant", 64'(t_grant), 64'(e.tg));
            end
        end
    end

    task automatic hold_reset_checks();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_type", 64'(out_type), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_t_grant", 64'(t_grant), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
`ifdef ARB_STATS_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        chk("rst_msg_cnt", 64'(msg_cnt), 64'(0));
`endif
    endtask

    initial begin
        int guard;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_type  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        hold_reset_checks();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Full load of single-beat messages: strict rotation 0,1,2,3,...
        pv = 100; pr = 100; maxlen = 1;
        run_cycles(20);
        // Downstream stalled with everyone valid.
        pr = 0;
        run_cycles(5);
        pv = 80; pr = 100; maxlen = 3;
        run_cycles(300);
        pv = 60; pr = 50; maxlen = 4;
        run_cycles(800);

        // Reset in the middle of a locked multi-beat message.
        pv = 100; pr = 100; maxlen = 4;
        guard = 0;
        while (lock < 0 && guard < 200) begin
            run_cycles(1);
            guard++;
        end
        chk("lock_reached", 64'(lock >= 0), 64'(1));
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        model_reset();
        #1;
        hold_reset_checks();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // All valid after release: req 0 must win first.
        pv = 100; pr = 70; maxlen = 3;
        run_cycles(300);
        pv = 40; pr = 90; maxlen = 2;
        run_cycles(300);

        // Drain.
        pv = 0; pr = 100;
        run_cycles(6);
        @(posedge clk);
        if (have_pend) begin
            exp_q.push_back(pend);
            have_pend = 1'b0;
        end
        @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
`ifdef ARB_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
        for (int i = 0; i < N; i++)
            chk("msg_cnt", 64'(msg_cnt[i*16 +: 16]), 64'(msg_exp[i]));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_msg_arbiter.md
Name: tx_msg_arbiter

Overview:
- Shares the single Logic→TX stage between NUM_REQ message sources, e.g. decision logic, cancel generator and heartbeat.
- Arbitration is round-robin per message. A multi-beat message keeps its grant locked until its last beat is accepted.
- Output is registered with the same valid/ready register semantics as the existing pipeline stages.
- Tags each message with the cycle_cnt value at grant, for latency measurement.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TYPE_W, 8, message type width
- DATA_W, 32, message data width
- SRC_W, $clog2(NUM_REQ), source index width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last beat of message
- req_type  in  NUM_REQ*TYPE_W  packed types; requester i at [i*TYPE_W +: TYPE_W]
- req_data  in  NUM_REQ*DATA_W  packed data
- req_ready  out  NUM_REQ  per-requester ready
- out_valid  out  1  output register valid
- out_type  out  TYPE_W  registered type
- out_data  out  DATA_W  registered data
- out_src  out  SRC_W  index of the requester that sourced the beat
- out_last  out  1  registered last flag
- out_ready  in  1  downstream ready
- cycle_cnt  in  32  free-running cycle counter
- t_grant  out  32  cycle_cnt latched when the first beat of a message is accepted
- busy  out  1  high while state is ARB_LOCKED

Behaviour:
- Reset values: out_valid=0, out_type/out_data/out_src/out_last=0, t_grant=0, busy=0, rr_ptr=0, state=ARB_IDLE, lock_idx=0.
- can_accept = !out_valid || out_ready.
- req_ready[i] = can_accept && (grant_idx==i) && grant_vld. Ready is never asserted for a non-granted requester.
- A beat transfers when req_valid[i] && req_ready[i]. It appears on the output the next cycle (latency 1).
- When no transfer occurs and out_ready=1, out_valid clears. Otherwise the register holds.

State ARB_IDLE:
- grant_idx is the first requester with valid set, searching from rr_ptr upward with wrap NUM_REQ-1→0. grant_vld=|req_valid.
- On transfer, t_grant<=cycle_cnt.
- If req_last=1: stay in IDLE and set rr_ptr<=(grant_idx+1) mod NUM_REQ.
- Else: lock_idx<=grant_idx and go to ARB_LOCKED.

State ARB_LOCKED:
- grant_idx=lock_idx and grant_vld=req_valid[lock_idx].
- Other requesters stall, even if the locked source drops valid. No interleaving: bubbles are acceptable.
- On a transfer with req_last=1: go to IDLE and set rr_ptr<=(lock_idx+1) mod NUM_REQ.
- t_grant is not updated within a message.

Boundary conditions:
- All requesters valid: strict rotation, each granted once per NUM_REQ messages.
- out_ready=0 with out_valid=1: no req_ready is asserted. The grant decision is combinational and re-evaluated each cycle in IDLE, so the grant is not sticky before the first beat.
- Simultaneous drain and fill (out_valid && out_ready && transfer): the register reloads and out_valid stays 1, giving full throughput.
- Single requester: grant every cycle and rr_ptr wraps harmlessly.
- Reset mid-message: everything returns to reset values. Any partially sent message is dropped, and the downstream must resynchronise on a type field.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs msg_cnt (out, NUM_REQ*16) and stall_cnt (out, 32).
  - msg_cnt: per-requester count of completed messages (last-beat transfers), saturating at 16'hFFFF.
  - stall_cnt: counts cycles with out_valid && !out_ready, saturating at 32'hFFFFFFFF.
  - Both reset to 0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package tx_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t
  - localparams MSG_TYPE_W=8, MSG_DATA_W=32, STAT_MSG_W=16
- Sub-module rr_arbiter:
  - Purely combinational: inputs req[NUM_REQ] and ptr[SRC_W]; outputs gnt_idx and gnt_vld.
  - Instantiated once. It is used only in ARB_IDLE.

Test Plan:
- Reset, then req_valid=4'b1111 all single-beat, out_ready=1 → out_src sequence 0,1,2,3,0; out_valid stays high; t_grant increments by 1 each message.
- Requester 1 sends a 3-beat message (last on beat 3) while req 2 is valid → out_src=1,1,1 then 2; busy=1 for beats 1–2 only.
- Locked req 1 drops valid for 2 cycles mid-message, req 0 valid → no req0 ready; out_valid gap of 2 cycles; message resumes from req 1.
- out_ready=0 for 5 cycles with all valid → out holds its first beat; req_ready=0; with ARB_STATS_EN, stall_cnt=5.
- Assert rst_n=0 during beat 2 of a locked message → next cycle out_valid=0, busy=0, t_grant=0; first grant after release goes to req 0.
- NUM_REQ=2, req_valid=2'b01 only, continuously → req 0 granted every cycle; rr_ptr wraps without a missed beat; with ARB_STATS_EN, msg_cnt[0] counts 1 per cycle.
